// File: rtl/osmanip_pkg.sv
// Shared types for the OSMANIP move sequencer: FSM states, motor codes and
// the queued command record.
package osmanip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_SETTLE
    } state_t;

    localparam int NUM_MOTORS = 6;

    localparam logic [2:0] MOTOR_XA = 3'd0;
    localparam logic [2:0] MOTOR_XB = 3'd1;
    localparam logic [2:0] MOTOR_YA = 3'd2;
    localparam logic [2:0] MOTOR_YB = 3'd3;
    localparam logic [2:0] MOTOR_ZA = 3'd4;
    localparam logic [2:0] MOTOR_ZB = 3'd5;

    typedef struct packed {
        logic [2:0] motor;
        logic       dir;
        logic [1:0] quarters;
    } cmd_t;

    function automatic logic motor_is_valid(input logic [2:0] motor);
        return motor <= MOTOR_ZB;
    endfunction

    // Odd codes are the B motors, which share the B direction line.
    function automatic logic motor_is_b(input logic [2:0] motor);
        return motor[0];
    endfunction

endpackage

// File: rtl/osmanip_cmd_fifo.sv
// Show-ahead command queue: the head entry is visible on o_data whenever
// the queue is non-empty, so the sequencer can decide and pop in one cycle.
module osmanip_cmd_fifo
    import osmanip_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  cmd_t                    i_data,
    input  logic                    i_pop,
    output cmd_t                    o_data,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_empty,
    output logic                    o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   LVL_ONE  = 1;
    localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LVL_FULL);

endmodule

// File: rtl/osmanip_move_sequencer.sv
// Queued stepper-move sequencer: pops quarter-turn commands and emits step
// pulses with direction setup and post-move settle time.
module osmanip_move_sequencer
    import osmanip_pkg::*;
#(
    parameter int STEP_HALF       = 25000,
    parameter int STEPS_PER_QTURN = 50,
    parameter int DIR_SETUP       = 4,
    parameter int SETTLE          = 50000,
    parameter int FIFO_DEPTH      = 8
)(
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_motor,
    input  logic                         cmd_dir,
    input  logic [1:0]                   cmd_quarters,
    input  logic                         enable,
    input  logic                         abort,
    output logic                         o_mxa,
    output logic                         o_mxb,
    output logic                         o_mya,
    output logic                         o_myb,
    output logic                         o_mza,
    output logic                         o_mzb,
    output logic                         o_dira,
    output logic                         o_dirb,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         err_sticky
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [31:0]             r_cnt;
    logic [31:0]             w_cnt_next;
    logic [15:0]             r_remaining;
    logic [15:0]             w_remaining_next;
    logic [2:0]              r_motor;
    logic                    r_dira;
    logic                    r_dirb;
    logic                    r_err;
    logic [NUM_MOTORS-1:0]   r_step;
    logic [NUM_MOTORS-1:0]   w_step_next;
    cmd_t                    w_push_cmd;
    cmd_t                    w_head;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_load;
    logic                    w_fifo_empty;
    logic                    w_fifo_full;

    assign cmd_ready  = !w_fifo_full && !abort;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_push     = w_accept && motor_is_valid(cmd_motor);
    assign w_push_cmd = cmd_t'{motor: cmd_motor, dir: cmd_dir, quarters: cmd_quarters};

    osmanip_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_flush (abort),
        .i_push  (w_push),
        .i_data  (w_push_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_level (fifo_level),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_remaining_next = r_remaining;
        w_pop            = 1'b0;
        w_load           = 1'b0;
        if (abort) begin
            w_state_next     = ST_IDLE;
            w_cnt_next       = '0;
            w_remaining_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty && enable) begin
                        w_pop = 1'b1;
                        // A zero-quarter entry is simply consumed.
                        if (w_head.quarters != 2'd0) begin
                            w_load           = 1'b1;
                            w_remaining_next = 16'(w_head.quarters) * 16'(STEPS_PER_QTURN);
                            w_cnt_next       = '0;
                            w_state_next     = ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == 32'(DIR_SETUP)) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_STEP_HI;
                    end else begin
                        w_cnt_next = r_cnt + 32'd1;
                    end
                end
                ST_STEP_HI: begin
                    if (r_cnt == 32'(STEP_HALF - 1)) begin
                        w_cnt_next       = '0;
                        w_remaining_next = r_remaining - 16'd1;
                        w_state_next     = ST_STEP_LO;
                    end else begin
                        w_cnt_next = r_cnt + 32'd1;
                    end
                end
                ST_STEP_LO: begin
                    // Counter parks at the last low cycle while paused.
                    if (r_cnt != 32'(STEP_HALF - 1)) begin
                        w_cnt_next = r_cnt + 32'd1;
                    end else if (r_remaining == 16'd0) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_SETTLE;
                    end else if (enable) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_STEP_HI;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 32'(SETTLE - 1)) begin
                        w_cnt_next   = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + 32'd1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_step_decode
        assign w_step_next[gi] = (w_state_next == ST_STEP_HI) && (r_motor == 3'(gi));
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_remaining <= '0;
            r_motor     <= '0;
            r_dira      <= 1'b0;
            r_dirb      <= 1'b0;
            r_err       <= 1'b0;
            r_step      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_remaining <= w_remaining_next;
            r_step      <= w_step_next;
            if (w_load) begin
                r_motor <= w_head.motor;
                if (motor_is_b(w_head.motor)) begin
                    r_dirb <= w_head.dir;
                end else begin
                    r_dira <= w_head.dir;
                end
            end
            if (w_accept && !motor_is_valid(cmd_motor)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_mxa      = r_step[MOTOR_XA];
    assign o_mxb      = r_step[MOTOR_XB];
    assign o_mya      = r_step[MOTOR_YA];
    assign o_myb      = r_step[MOTOR_YB];
    assign o_mza      = r_step[MOTOR_ZA];
    assign o_mzb      = r_step[MOTOR_ZB];
    assign o_dira     = r_dira;
    assign o_dirb     = r_dirb;
    assign err_sticky = r_err;
    assign busy       = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_osmanip_move_sequencer.sv
// Directed bench for osmanip_move_sequencer with short timing parameters.
module tb_osmanip_move_sequencer;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_motor = 3'd0;
    logic       cmd_dir = 1'b0;
    logic [1:0] cmd_quarters = 2'd0;
    logic       enable = 1'b1;
    logic       abort = 1'b0;
    logic       o_mxa, o_mxb, o_mya, o_myb, o_mza, o_mzb;
    logic       o_dira, o_dirb;
    logic       busy;
    logic [3:0] fifo_level;
    logic       err_sticky;

    osmanip_move_sequencer #(
        .STEP_HALF       (2),
        .STEPS_PER_QTURN (3),
        .DIR_SETUP       (1),
        .SETTLE          (5),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_motor     (cmd_motor),
        .cmd_dir       (cmd_dir),
        .cmd_quarters  (cmd_quarters),
        .enable        (enable),
        .abort         (abort),
        .o_mxa         (o_mxa),
        .o_mxb         (o_mxb),
        .o_mya         (o_mya),
        .o_myb         (o_myb),
        .o_mza         (o_mza),
        .o_mzb         (o_mzb),
        .o_dira        (o_dira),
        .o_dirb        (o_dirb),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .err_sticky    (err_sticky)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Pulse monitor: counts rising edges per motor, records order and timing.
    logic [5:0] w_steps;
    assign w_steps = {o_mzb, o_mza, o_myb, o_mya, o_mxb, o_mxa};
    logic [5:0] prev_steps = 6'd0;
    int pulse_cnt [6] = '{0, 0, 0, 0, 0, 0};
    int rise_motor [$];
    int rise_cyc [$];
    int hi_run = 0;
    int shape_err = 0;
    int onehot_err = 0;

    always @(negedge clk_clk) begin
        if ($countones(w_steps) > 1) onehot_err++;
        for (int i = 0; i < 6; i++) begin
            if (w_steps[i] && !prev_steps[i]) begin
                pulse_cnt[i]++;
                rise_motor.push_back(i);
                rise_cyc.push_back(cyc);
            end
        end
        if (w_steps != 6'd0) begin
            hi_run++;
        end else begin
            if (prev_steps != 6'd0 && hi_run != 2) shape_err++;
            hi_run = 0;
        end
        prev_steps = w_steps;
    end

    function automatic int total_pulses();
        int s = 0;
        for (int i = 0; i < 6; i++) s += pulse_cnt[i];
        return s;
    endfunction

    task automatic send(input int m, input int d, input int q, output int acc);
        @(negedge clk_clk);
        cmd_valid    = 1'b1;
        cmd_motor    = 3'(m);
        cmd_dir      = d[0];
        cmd_quarters = 2'(q);
        @(posedge clk_clk);
        #1;
        acc       = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk_clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int fall);
        fall = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_clk);
            #1;
            if (!busy) begin
                fall = cyc;
                break;
            end
        end
        check_eq(tag, int'(busy), 0);
    endtask

    task automatic wait_rise(input string tag, input int m, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_clk);
            #1;
            if (pulse_cnt[m] >= target) break;
        end
        check_eq(tag, int'(pulse_cnt[m] >= target), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, fall, b, n_acc, tot;
        int b0, b1, b2, b3, b4, b5, bs;

        // Reset state
        idle_cycles(3);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_level", int'(fifo_level), 0);
        check_eq("rst_err", int'(err_sticky), 0);
        check_eq("rst_dirs", int'({o_dira, o_dirb}), 0);
        check_eq("rst_steps", int'(w_steps), 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        #1;
        check_eq("rst_ready", int'(cmd_ready), 1);

        // Basic move: YA clockwise, two quarters -> 6 pulses
        b  = rise_cyc.size();
        bs = shape_err;
        send(2, 1, 2, acc);
        wait_idle("t1_idle", 100, fall);
        check_eq("t1_count", pulse_cnt[2], 6);
        check_eq("t1_total", total_pulses(), 6);
        check_eq("t1_first_rise", rise_cyc[b] - acc, 3);
        for (int k = 1; k < 6; k++)
            check_eq("t1_period", rise_cyc[b + k] - rise_cyc[b + k - 1], 4);
        check_eq("t1_shape", shape_err - bs, 0);
        check_eq("t1_busy_fall", fall - acc, 32);
        check_eq("t1_dira", int'(o_dira), 1);
        check_eq("t1_dirb", int'(o_dirb), 0);

        // Invalid motor code, then zero-quarter command
        tot = total_pulses();
        send(7, 0, 1, acc);
        idle_cycles(3);
        check_eq("t2_err", int'(err_sticky), 1);
        check_eq("t2_level", int'(fifo_level), 0);
        check_eq("t2_busy", int'(busy), 0);
        send(3, 1, 0, acc);
        idle_cycles(10);
        check_eq("t2_q0_level", int'(fifo_level), 0);
        check_eq("t2_q0_busy", int'(busy), 0);
        check_eq("t2_q0_dirb", int'(o_dirb), 0);
        check_eq("t2_q0_dira", int'(o_dira), 1);
        check_eq("t2_no_pulses", total_pulses() - tot, 0);

        // Fill queue while paused, then drain in order
        enable = 1'b0;
        b  = rise_motor.size();
        bs = shape_err;
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_clk);
            if (i == 8) check_eq("t3_ready_full", int'(cmd_ready), 0);
            if (cmd_ready) n_acc++;
            cmd_valid    = 1'b1;
            cmd_motor    = 3'(i % 6);
            cmd_dir      = 1'((i % 2));
            cmd_quarters = 2'd1;
        end
        @(negedge clk_clk);
        cmd_valid = 1'b0;
        #1;
        check_eq("t3_accepted", n_acc, 8);
        check_eq("t3_level_full", int'(fifo_level), 8);
        check_eq("t3_busy_paused", int'(busy), 1);
        enable = 1'b1;
        @(negedge clk_clk);
        #1;
        check_eq("t3_ready_back", int'(cmd_ready), 1);
        check_eq("t3_level_pop", int'(fifo_level), 7);
        wait_idle("t3_idle", 500, fall);
        check_eq("t3_rises", rise_motor.size() - b, 24);
        if (rise_motor.size() - b == 24) begin
            for (int k = 0; k < 24; k++)
                check_eq("t3_order", rise_motor[b + k], (k / 3) % 6);
        end
        check_eq("t3_shape", shape_err - bs, 0);

        // Abort during the third pulse, with a simultaneous command offered
        b2 = pulse_cnt[2];
        b3 = pulse_cnt[3];
        b4 = pulse_cnt[4];
        send(2, 1, 2, acc);
        send(4, 0, 1, acc2);
        check_eq("t4_level_queued", int'(fifo_level), 1);
        wait_rise("t4_third_rise", 2, b2 + 3, 60);
        abort        = 1'b1;
        cmd_valid    = 1'b1;
        cmd_motor    = 3'd3;
        cmd_quarters = 2'd1;
        #1;
        check_eq("t4_ready_abort", int'(cmd_ready), 0);
        @(posedge clk_clk);
        #1;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk_clk);
        #1;
        check_eq("t4_mya_low", int'(o_mya), 0);
        check_eq("t4_level", int'(fifo_level), 0);
        check_eq("t4_busy", int'(busy), 0);
        idle_cycles(20);
        check_eq("t4_ya_pulses", pulse_cnt[2] - b2, 3);
        check_eq("t4_za_flushed", pulse_cnt[4] - b4, 0);
        check_eq("t4_yb_blocked", pulse_cnt[3] - b3, 0);
        check_eq("t4_dira_kept", int'(o_dira), 1);
        check_eq("t4_err_kept", int'(err_sticky), 1);
        b5 = pulse_cnt[5];
        send(5, 1, 1, acc);
        wait_idle("t4_after_idle", 100, fall);
        check_eq("t4_after_pulses", pulse_cnt[5] - b5, 3);
        check_eq("t4_after_dirb", int'(o_dirb), 1);

        // Pause during pulse 2, resume for the remaining 4
        b0 = pulse_cnt[0];
        bs = shape_err;
        send(0, 0, 2, acc);
        wait_rise("t5_second_rise", 0, b0 + 2, 60);
        enable = 1'b0;
        idle_cycles(12);
        check_eq("t5_paused_count", pulse_cnt[0] - b0, 2);
        check_eq("t5_paused_low", int'(o_mxa), 0);
        check_eq("t5_paused_busy", int'(busy), 1);
        enable = 1'b1;
        wait_idle("t5_idle", 100, fall);
        check_eq("t5_total", pulse_cnt[0] - b0, 6);
        check_eq("t5_shape", shape_err - bs, 0);
        check_eq("t5_dira", int'(o_dira), 0);

        // Asynchronous reset mid-pulse
        b1 = pulse_cnt[1];
        send(1, 1, 1, acc);
        wait_rise("t6_rise", 1, b1 + 1, 30);
        check_eq("t6_mxb_high", int'(o_mxb), 1);
        reset_reset_n = 1'b0;
        #1;
        check_eq("t6_mxb_async", int'(o_mxb), 0);
        check_eq("t6_steps", int'(w_steps), 0);
        check_eq("t6_busy", int'(busy), 0);
        check_eq("t6_level", int'(fifo_level), 0);
        check_eq("t6_err", int'(err_sticky), 0);
        check_eq("t6_dirs", int'({o_dira, o_dirb}), 0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        #1;
        check_eq("t6_ready", int'(cmd_ready), 1);

        check_eq("onehot", onehot_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
